regfile_sb: RTL and testbench

Parametrised, scoreboarded register file for the riscv16 core: DEPTH × DATA_W storage, two combinational read ports, one writeback port, register 0 hardwired to zero. It adds a hardware clear sweep after reset, per-register busy (pending-write) tracking with a hazard output for the issue stage, and optional writeback-to-read bypass. It sits between decode/issue (reads, busy marking) and writeback.

---
 rtl/riscv16_pkg.sv | 12 +
 rtl/regfile_sb_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 134 +++++++++++++
 tb/tb_regfile_sb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv16_pkg.sv
// Shared types and default sizes for the riscv16 register file.
package riscv16_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 16;
    localparam int RF_DEPTH  = 8;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module reg_scoreboard
    import riscv16_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              byp1,
    input  logic              byp2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_tgt,
    input  logic              we_reg,
    input  logic [ADDR_W-1:0] tgt,
    output logic              src1_busy,
    output logic              src2_busy,
    output logic              hazard
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             issue_ok;
    logic             clear_ok;

    always_comb begin
        src1_busy = (src1 != '0) && busy_q[src1] && !byp1;
        src2_busy = (src2 != '0) && busy_q[src2] && !byp2;
        hazard    = run && iss_valid && (src1_busy || src2_busy || busy_q[iss_tgt]);
        issue_ok  = run && iss_valid && !hazard && (iss_tgt != '0);
        clear_ok  = run && we_reg && (tgt != '0);
    end

    assign busy_d[0] = 1'b0;

    // Set is evaluated after clear so a same-edge issue keeps the register busy.
    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_busy
            always_comb begin
                busy_d[gi] = busy_q[gi];
                if (clear_ok && (tgt == ADDR_W'(gi))) begin
                    busy_d[gi] = 1'b0;
                end
                if (issue_ok && (iss_tgt == ADDR_W'(gi))) begin
                    busy_d[gi] = 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file with post-reset clear sweep.
// Optional same-cycle writeback-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_sb
    import riscv16_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] src1_val,
    output logic [DATA_W-1:0] src2_val,
    output logic              src1_busy,
    output logic              src2_busy,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_tgt,
    output logic              hazard,
    input  logic              we_reg,
    input  logic [ADDR_W-1:0] tgt,
    input  logic [DATA_W-1:0] write_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q;
    rf_state_t         state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic              run;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              byp1;
    logic              byp2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            idx_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RF_INIT: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN:  state_d = RF_RUN;
            default: state_d = RF_INIT;
        endcase
    end

    always_comb begin
        run   = (state_q == RF_RUN);
        ready = run;
    end

    // Sweep writes own the port during INIT; a reset edge drops any writeback.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (rst_n) begin
            if (!run) begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
            end else if (we_reg && (tgt != '0)) begin
                wr_en   = 1'b1;
                wr_addr = tgt;
                wr_data = write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = run && we_reg && (tgt != '0) && (tgt == src1);
    assign byp2 = run && we_reg && (tgt != '0) && (tgt == src2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        src1_val = '0;
        src2_val = '0;
        if (src1 != '0) begin
            src1_val = byp1 ? write_data : regs_q[src1];
        end
        if (src2 != '0) begin
            src2_val = byp2 ? write_data : regs_q[src2];
        end
    end

    reg_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .src1      (src1),
        .src2      (src2),
        .byp1      (byp1),
        .byp2      (byp2),
        .iss_valid (iss_valid),
        .iss_tgt   (iss_tgt),
        .we_reg    (we_reg),
        .tgt       (tgt),
        .src1_busy (src1_busy),
        .src2_busy (src2_busy),
        .hazard    (hazard)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table of vectors followed by randomized traffic against a behavioural model.
module tb_regfile_sb;
    import riscv16_pkg::*;

    localparam int DW    = RF_DATA_W;
    localparam int DEPTH = RF_DEPTH;
    localparam int AW    = $clog2(DEPTH);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ready;
    logic [AW-1:0] src1, src2, iss_tgt, tgt;
    logic [DW-1:0] src1_val, src2_val, write_data;
    logic          src1_busy, src2_busy, iss_valid, hazard, we_reg;

    regfile_sb #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready      (ready),
        .src1       (src1),
        .src2       (src2),
        .src1_val   (src1_val),
        .src2_val   (src2_val),
        .src1_busy  (src1_busy),
        .src2_busy  (src2_busy),
        .iss_valid  (iss_valid),
        .iss_tgt    (iss_tgt),
        .hazard     (hazard),
        .we_reg     (we_reg),
        .tgt        (tgt),
        .write_data (write_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          chk;
        logic        rst;
        int          s1, s2;
        bit          iv;
        int          it;
        bit          we;
        int          tg;
        logic [15:0] wd;
        bit          e_rdy;
        logic [15:0] e_v1, e_v2;
        bit          e_b1, e_b2, e_hz;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: register contents, pending-write set, and remaining sweep edges.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy[DEPTH];
    int            sweep_left = DEPTH - 1;
    int            sweep_next = 1;

    function automatic vec_t mk(string nm, bit c, logic r, int a, int b, bit iv, int it,
                                bit we, int tg, logic [15:0] wd, bit rdy,
                                logic [15:0] v1, logic [15:0] v2, bit b1, bit b2, bit hz);
        vec_t v;
        v.name = nm; v.chk = c; v.rst = r; v.s1 = a; v.s2 = b; v.iv = iv; v.it = it;
        v.we = we; v.tg = tg; v.wd = wd; v.e_rdy = rdy; v.e_v1 = v1; v.e_v2 = v2;
        v.e_b1 = b1; v.e_b2 = b2; v.e_hz = hz;
        return v;
    endfunction

    function automatic bit m_ready();
        return sweep_left == 0;
    endfunction

    function automatic bit m_hit(int s);
        return BYP && m_ready() && we_reg && (tgt != 0) && (int'(tgt) == s);
    endfunction

    function automatic logic [15:0] m_val(int s);
        if (s == 0) return 16'h0000;
        if (m_hit(s)) return write_data;
        return m_mem[s];
    endfunction

    function automatic bit m_bsy(int s);
        if (s == 0 || m_hit(s)) return 1'b0;
        return m_busy[s];
    endfunction

    function automatic bit m_hz();
        return m_ready() && iss_valid &&
               (m_bsy(int'(src1)) || m_bsy(int'(src2)) || m_busy[int'(iss_tgt)]);
    endfunction

    task automatic m_edge();
        bit hz;
        hz = m_hz();
        if (!rst_n) begin
            sweep_left = DEPTH - 1;
            sweep_next = 1;
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        end else if (sweep_left > 0) begin
            m_mem[sweep_next] = '0;
            sweep_next++;
            sweep_left--;
        end else begin
            if (we_reg && tgt != 0) begin
                m_mem[tgt]  = write_data;
                m_busy[tgt] = 1'b0;
            end
            if (iss_valid && !hz && iss_tgt != 0) m_busy[iss_tgt] = 1'b1;
        end
    endtask

    task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endtask

    task automatic check_all(string tag, bit rdy, logic [15:0] v1, logic [15:0] v2,
                             bit b1, bit b2, bit hz);
        cmp({tag, ".ready"},     16'(ready),     16'(rdy));
        cmp({tag, ".src1_val"},  src1_val,       v1);
        cmp({tag, ".src2_val"},  src2_val,       v2);
        cmp({tag, ".src1_busy"}, 16'(src1_busy), 16'(b1));
        cmp({tag, ".src2_busy"}, 16'(src2_busy), 16'(b2));
        cmp({tag, ".hazard"},    16'(hazard),    16'(hz));
    endtask

    task automatic drive(logic r, int a, int b, bit iv, int it, bit we, int tg, logic [15:0] wd);
        rst_n      = r;
        src1       = AW'(a);
        src2       = AW'(b);
        iss_valid  = iv;
        iss_tgt    = AW'(it);
        we_reg     = we;
        tgt        = AW'(tg);
        write_data = wd;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end

        vecs.push_back(mk("pre_rst", 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0, 16'h0, 0, 0, 0));
        vecs.push_back(mk("rst_hold", 1, 0, 0, 0, 1, 3, 1, 3, 16'h1111, 0, 16'h0, 16'h0, 0, 0, 0));
        for (int i = 0; i < DEPTH - 1; i++)
            vecs.push_back(mk("sweep", 1, 1, 0, 0, 1, 3, 1, 3, 16'h1111, 0, 16'h0, 16'h0, 0, 0, 0));
        vecs.push_back(mk("run_clr", 1, 1, 1, 2, 0, 0, 1, 3, 16'hBEEF, 1, 16'h0, 16'h0, 0, 0, 0));
        vecs.push_back(mk("rd_beef", 1, 1, 3, 7, 0, 0, 1, 0, 16'h1234, 1, 16'hBEEF, 16'h0, 0, 0, 0));
        vecs.push_back(mk("iss5", 1, 1, 0, 3, 1, 5, 0, 0, 16'h0000, 1, 16'h0, 16'hBEEF, 0, 0, 0));
        vecs.push_back(mk("haz5", 1, 1, 0, 5, 1, 6, 0, 0, 16'h0000, 1, 16'h0, 16'h0, 0, 1, 1));
        vecs.push_back(mk("wb5", 1, 1, 5, 6, 0, 0, 1, 5, 16'h00AA, 1,
                          BYP ? 16'h00AA : 16'h0, 16'h0, BYP ? 1'b0 : 1'b1, 0, 0));
        vecs.push_back(mk("rd_aa", 1, 1, 5, 2, 1, 2, 1, 2, 16'h0F0F, 1,
                          16'h00AA, BYP ? 16'h0F0F : 16'h0, 0, 0, 0));
        vecs.push_back(mk("collide", 1, 1, 2, 0, 1, 0, 0, 0, 16'h0000, 1, 16'h0F0F, 16'h0, 1, 0, 1));
        vecs.push_back(mk("iss4", 1, 1, 0, 0, 1, 4, 0, 0, 16'h0000, 1, 16'h0, 16'h0, 0, 0, 0));
        vecs.push_back(mk("byp4", 1, 1, 4, 0, 0, 0, 1, 4, 16'h5555, 1,
                          BYP ? 16'h5555 : 16'h0, 16'h0, BYP ? 1'b0 : 1'b1, 0, 0));
        vecs.push_back(mk("rd5555", 1, 1, 4, 0, 1, 6, 1, 1, 16'h7777, 1, 16'h5555, 16'h0, 0, 0, 0));
        vecs.push_back(mk("pre_mid", 1, 1, 1, 6, 0, 0, 0, 0, 16'h0000, 1, 16'h7777, 16'h0, 0, 1, 0));
        vecs.push_back(mk("mid_rst", 0, 0, 6, 1, 0, 0, 1, 1, 16'hAAAA, 0, 16'h0, 16'h0, 0, 0, 0));
        vecs.push_back(mk("resweep", 1, 1, 6, 1, 1, 3, 1, 5, 16'h9999, 0, 16'h0, 16'h7777, 0, 0, 0));
        for (int i = 0; i < DEPTH - 2; i++)
            vecs.push_back(mk("resweep", 1, 1, 1, 0, 1, 1, 1, 1, 16'hABCD, 0, 16'h0, 16'h0, 0, 0, 0));
        vecs.push_back(mk("post", 1, 1, 1, 5, 0, 0, 0, 0, 16'h0000, 1, 16'h0, 16'h0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].s1, vecs[i].s2, vecs[i].iv, vecs[i].it,
                  vecs[i].we, vecs[i].tg, vecs[i].wd);
            @(negedge clk);
            if (vecs[i].chk)
                check_all($sformatf("v%0d_%s", i, vecs[i].name), vecs[i].e_rdy, vecs[i].e_v1,
                          vecs[i].e_v2, vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_hz);
            $display("vec %0d %s rst_n=%0b src=%0d/%0d val=%04h/%04h busy=%0b%0b hz=%0b rdy=%0b",
                     i, vecs[i].name, rst_n, src1, src2, src1_val, src2_val,
                     src1_busy, src2_busy, hazard, ready);
            @(posedge clk);
            m_edge();
            #1;
        end

        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 63) != 0), $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, DEPTH - 1), 1'($urandom), $urandom_range(0, DEPTH - 1),
                  1'($urandom), $urandom_range(0, DEPTH - 1), 16'($urandom));
            @(negedge clk);
            check_all($sformatf("rnd%0d", n), m_ready(), m_val(int'(src1)), m_val(int'(src2)),
                      m_bsy(int'(src1)), m_bsy(int'(src2)), m_hz());
            $display("rnd %0d rst_n=%0b src=%0d/%0d iss=%0b>%0d we=%0b>%0d:%04h val=%04h/%04h hz=%0b",
                     n, rst_n, src1, src2, iss_valid, iss_tgt, we_reg, tgt, write_data,
                     src1_val, src2_val, hazard);
            @(posedge clk);
            m_edge();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
